dmem_write_buffer: RTL and testbench

//  Posted-store buffer between the mips core's data port and dmem.
//  - Absorbs sw stores in a small FIFO; drains them to dmem when the shared address port is idle.
//  - Forwards buffered data to loads to the same word.
//  - Stalls the core only when a store arrives and the FIFO is full.

---
 rtl/dmem_write_buffer_pkg.sv | 16 +
 rtl/wbuf_fifo.sv | 91 +++++++++
 rtl/dmem_write_buffer.sv | 113 +++++++++++
 tb/tb_dmem_write_buffer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_write_buffer_pkg.sv
// Shared constants and types for the posted-store write buffer.
// Imported by the FIFO and the top-level buffer.
package dmem_write_buffer_pkg;

    localparam int TMIPS_AW = 32;
    localparam int TMIPS_DW = 32;
    localparam int WB_DEPTH = 4;

    // Owner of the shared dmem address port in a given cycle
    typedef enum logic [1:0] {
        PORT_IDLE  = 2'd0,
        PORT_LOAD  = 2'd1,
        PORT_DRAIN = 2'd2
    } port_sel_e;

endpackage

// File: rtl/wbuf_fifo.sv
// Store FIFO: entry storage, head/tail/count, and a per-entry valid
// vector so the forwarding logic can tell live slots from stale ones.
module wbuf_fifo #(
    parameter int DEPTH = 4,
    parameter int WA    = 30,
    parameter int DW    = 32,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = PW + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push_i,
    input  logic [WA-1:0]                 push_addr_i,
    input  logic [DW-1:0]                 push_data_i,
    input  logic                          pop_i,
    output logic [WA-1:0]                 head_addr_o,
    output logic [DW-1:0]                 head_data_o,
    output logic [PW-1:0]                 head_ptr_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [DEPTH-1:0]              valid_o,
    output logic [DEPTH-1:0][WA-1:0]      ent_addr_o,
    output logic [DEPTH-1:0][DW-1:0]      ent_data_o
);

    logic [DEPTH-1:0][WA-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [PW-1:0]            head_q, head_d;
    logic [PW-1:0]            tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     do_pop;
    logic [PW-1:0]            offs;

    assign do_pop      = pop_i && (count_q != '0);
    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];
    assign head_ptr_o  = head_q;
    assign ent_addr_o  = addr_q;
    assign ent_data_o  = data_q;

    // Next pointer and occupancy values; push and pop together keep count
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) tail_d = tail_q + PW'(1);
        if (do_pop) head_d = head_q + PW'(1);
        unique case ({push_i, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A slot is live when its distance from head is below the occupancy
    always_comb begin
        valid_o = '0;
        offs    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs       = PW'(i) - head_q;
            valid_o[i] = ({1'b0, offs} < count_q);
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage, written at tail on push
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (push_i) begin
            addr_q[tail_q] <= push_addr_i;
            data_q[tail_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-store buffer between the core data port and dmem: absorbs
// stores, drains them when the port is idle, forwards to loads.
module dmem_write_buffer
    import dmem_write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = TMIPS_AW,
    parameter int DW    = TMIPS_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_we,
    input  logic          cpu_re,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wd,
    output logic [DW-1:0] cpu_rd,
    output logic          cpu_stall,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          wb_empty
);

    localparam int WA = AW - 2;
    localparam int PW = $clog2(DEPTH);

    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;
    logic [WA-1:0]            head_addr;
    logic [DW-1:0]            head_data;
    logic [PW-1:0]            head_ptr;
    logic [DEPTH-1:0]         valid;
    logic [DEPTH-1:0][WA-1:0] ent_addr;
    logic [DEPTH-1:0][DW-1:0] ent_data;
    port_sel_e                sel;
    logic                     fwd_hit;
    logic [DW-1:0]            fwd_data;
    logic [PW-1:0]            idx;

    assign push      = cpu_we && !full;
    assign pop       = (sel == PORT_DRAIN);
    assign cpu_stall = cpu_we && full;
    assign wb_empty  = empty;

    wbuf_fifo #(
        .DEPTH (DEPTH),
        .WA    (WA),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_addr_i (cpu_addr[AW-1:2]),
        .push_data_i (cpu_wd),
        .pop_i       (pop),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .head_ptr_o  (head_ptr),
        .full_o      (full),
        .empty_o     (empty),
        .valid_o     (valid),
        .ent_addr_o  (ent_addr),
        .ent_data_o  (ent_data)
    );

    // Loads own the port; otherwise buffered stores drain
    always_comb begin
        sel = PORT_IDLE;
        if (cpu_re)      sel = PORT_LOAD;
        else if (!empty) sel = PORT_DRAIN;
    end

    // Drive the dmem port from the selected owner
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = cpu_addr;
        mem_wd   = head_data;
        unique case (sel)
            PORT_DRAIN: begin
                mem_we   = 1'b1;
                mem_addr = {head_addr, 2'b00};
            end
            default: begin
                mem_we   = 1'b0;
                mem_addr = cpu_addr;
            end
        endcase
    end

    // Walk oldest to youngest so the last live match is the newest store
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_ptr + PW'(k);
            if (valid[idx] && (ent_addr[idx] == cpu_addr[AW-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data[idx];
            end
        end
    end

    // Load data: forwarded entry wins over dmem
    always_comb begin
        cpu_rd = mem_rd;
        if (cpu_re && fwd_hit) cpu_rd = fwd_data;
    end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer with a small dmem model
// behind the buffer and hand-computed expectations.
module tb_dmem_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        cpu_stall;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        wb_empty;

    logic [31:0] dmem [64];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    dmem_write_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_addr  (cpu_addr),
        .cpu_wd    (cpu_wd),
        .cpu_rd    (cpu_rd),
        .cpu_stall (cpu_stall),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .wb_empty  (wb_empty)
    );

    assign mem_rd = dmem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) dmem[mem_addr[7:2]] <= mem_wd;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic re,
                         input logic [31:0] a, input logic [31:0] d);
        cpu_we   = we;
        cpu_re   = re;
        cpu_addr = a;
        cpu_wd   = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) dmem[i] = '0;
        dmem[24] = 32'h1234_5678;
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h10, 32'h11);

        // Reset held with a store request pending
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
            chk("rst_empty", {31'd0, wb_empty}, 32'd1);
            chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
            tick();
        end
        reset = 1'b1;
        #2;
        chk("rel_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rel_mem_we", {31'd0, mem_we}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("rel_buffered", {31'd0, wb_empty}, 32'd0);
        chk("rel_drain_we", {31'd0, mem_we}, 32'd1);
        chk("rel_drain_addr", mem_addr, 32'h10);
        chk("rel_drain_wd", mem_wd, 32'h11);
        tick();
        chk("rel_empty", {31'd0, wb_empty}, 32'd1);
        chk("rel_dmem4", dmem[4], 32'h11);

        // Single store then idle
        drive(1'b1, 1'b0, 32'h54, 32'h7);
        #2;
        chk("s2_stall", {31'd0, cpu_stall}, 32'd0);
        chk("s2_no_early_we", {31'd0, mem_we}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("s2_we", {31'd0, mem_we}, 32'd1);
        chk("s2_addr", mem_addr, 32'h54);
        chk("s2_wd", mem_wd, 32'h7);
        tick();
        chk("s2_empty", {31'd0, wb_empty}, 32'd1);
        chk("s2_dmem21", dmem[21], 32'h7);

        // Forwarding with drain blocked by loads
        drive(1'b1, 1'b1, 32'h50, 32'hA);
        tick();
        drive(1'b1, 1'b1, 32'h50, 32'hB);
        tick();
        drive(1'b0, 1'b1, 32'h50, 32'h0);
        #2;
        chk("fwd_young", cpu_rd, 32'hB);
        chk("fwd_no_drain", {31'd0, mem_we}, 32'd0);
        tick();
        drive(1'b0, 1'b1, 32'h60, 32'h0);
        #2;
        chk("fwd_miss", cpu_rd, 32'h1234_5678);
        chk("fwd_miss_addr", mem_addr, 32'h60);
        drive(1'b0, 1'b1, 32'h54, 32'h0);
        #2;
        chk("fwd_miss2", cpu_rd, 32'h7);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("fwd_drain1_wd", mem_wd, 32'hA);
        tick();
        chk("fwd_dmem20_a", dmem[20], 32'hA);
        #2;
        chk("fwd_drain2_wd", mem_wd, 32'hB);
        tick();
        chk("fwd_dmem20_b", dmem[20], 32'hB);
        chk("fwd_empty", {31'd0, wb_empty}, 32'd1);

        // Fill, then a fifth store stalls one cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'h80 + 32'(4 * i), 32'(i + 1));
            #2;
            chk("full_fill_stall", {31'd0, cpu_stall}, 32'd0);
            tick();
        end
        drive(1'b1, 1'b0, 32'h90, 32'h5);
        #2;
        chk("full_stall", {31'd0, cpu_stall}, 32'd1);
        chk("full_drain_we", {31'd0, mem_we}, 32'd1);
        chk("full_drain_addr", mem_addr, 32'h80);
        chk("full_drain_wd", mem_wd, 32'h1);
        tick();
        #2;
        chk("full_unstall", {31'd0, cpu_stall}, 32'd0);
        chk("full_next_addr", mem_addr, 32'h84);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        chk("full_empty", {31'd0, wb_empty}, 32'd1);
        chk("full_dmem32", dmem[32], 32'h1);
        chk("full_dmem35", dmem[35], 32'h4);
        chk("full_dmem36", dmem[36], 32'h5);

        // Push and drain together keep occupancy
        drive(1'b1, 1'b1, 32'hA0, 32'h21);
        tick();
        drive(1'b1, 1'b1, 32'hA4, 32'h22);
        tick();
        drive(1'b1, 1'b0, 32'hA8, 32'h23);
        #2;
        chk("pd_head", mem_addr, 32'hA0);
        chk("pd_stall", {31'd0, cpu_stall}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("pd_head2", mem_addr, 32'hA4);
        tick();
        #2;
        chk("pd_head3", mem_addr, 32'hA8);
        chk("pd_not_empty", {31'd0, wb_empty}, 32'd0);
        tick();
        chk("pd_empty", {31'd0, wb_empty}, 32'd1);

        // Six back-to-back stores cross the pointer wrap
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 32'hC0 + 32'(4 * i), 32'h30 + 32'(i));
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("wrap_empty", {31'd0, wb_empty}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("wrap_dmem", dmem[48 + i], 32'h30 + 32'(i));
        end

        // Asynchronous reset while a drain is in progress
        drive(1'b1, 1'b1, 32'hE0, 32'h77);
        tick();
        drive(1'b1, 1'b1, 32'hE4, 32'h78);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("ar_we_before", {31'd0, mem_we}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_we_drop", {31'd0, mem_we}, 32'd0);
        chk("ar_empty", {31'd0, wb_empty}, 32'd1);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("ar_no_write", {31'd0, mem_we}, 32'd0);
            tick();
        end
        chk("ar_dmem56", dmem[56], 32'h0);
        chk("ar_dmem57", dmem[57], 32'h0);
        chk("ar_final_empty", {31'd0, wb_empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
